// File: rtl/sha3_sched_pkg.sv
// Shared types and constants for the SHA3 job scheduler: FSM state encoding,
// digest width and the engine reset length.
package sha3_sched_pkg;

    localparam int HASH_W     = 512;
    localparam int RST_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_ENG_RST = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_RESP    = 3'd5
    } sched_state_e;

endpackage

// File: rtl/sha3_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant,
// done by rotating a doubled request vector and priority-encoding the result.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    localparam logic [IDX_W+1:0] NUM_L = (IDX_W+2)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [IDX_W:0]       base;
    logic [NUM_REQ-1:0]   rotated;
    logic [IDX_W:0]       offset;
    logic [IDX_W+1:0]     sum;

    assign req_dbl = {req, req};
    assign base    = {1'b0, last_grant} + (IDX_W+1)'(1);
    assign rotated = req_dbl[base +: NUM_REQ];

    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) offset = (IDX_W+1)'(i);
        end
    end

    // base + offset is below 2*NUM_REQ, so one conditional subtract is the modulo.
    assign sum       = {1'b0, base} + {1'b0, offset};
    assign grant_idx = (sum >= NUM_L) ? IDX_W'(sum - NUM_L) : IDX_W'(sum);
    assign any_req   = |req;
    assign grant     = any_req ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/sha3_job_scheduler.sv
// Shares one SHA3 burst engine among NUM_REQ requesters: round-robin grant,
// engine reset/start, watchdog-guarded wait for the digest, one-hot response.
module sha3_job_scheduler
    import sha3_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]     req_len,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ack,
    output logic                         rsp_error,
    output logic [HASH_W-1:0]            rsp_hash,
    output logic                         eng_reset,
    output logic                         eng_start,
    output logic [ADDR_W-1:0]            eng_base_addr,
    output logic [LEN_W-1:0]             eng_number_bytes,
    input  logic                         eng_out_ready,
    input  logic [HASH_W-1:0]            eng_hash,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output sched_state_e                 dbg_state
);

    // Handshakes: a requester holds req_valid (with addr/len) until its one-cycle
    // req_ready pulse; rsp_valid is held until the owner raises its rsp_ack bit.
    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam int               RCNT_W    = $clog2(RST_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);
    localparam logic [31:0]      WD_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      WD_PRE    = 32'(TIMEOUT_CYCLES - 2);

    sched_state_e        state, next_state;
    logic [IDX_W-1:0]    last_grant;
    logic [31:0]         watchdog;
    logic [RCNT_W-1:0]   rst_cnt;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;
    logic                wd_timeout, wd_abort_pre, len_zero;
    logic [NUM_REQ-1:0]  req_ready_d, rsp_valid_d;
    logic                eng_reset_d, eng_start_d, busy_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_req    (arb_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_len  = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign len_zero   = (eng_number_bytes == '0);
    assign wd_timeout = (watchdog == WD_LAST);
    // The abort reset must appear in the last WAIT cycle, so it is decided one cycle early.
    assign wd_abort_pre = (state == ST_WAIT) && !eng_out_ready && (watchdog == WD_PRE);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (arb_any) next_state = ST_GRANT;
            ST_GRANT:   next_state = len_zero ? ST_RESP : ST_ENG_RST;
            ST_ENG_RST: if (rst_cnt == RCNT_LAST) next_state = ST_START;
            ST_START:   next_state = ST_WAIT;
            ST_WAIT:    if (eng_out_ready || wd_timeout) next_state = ST_RESP;
            ST_RESP:    if (rsp_ack[grant_id]) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_d = '0;
        rsp_valid_d = '0;
        if (next_state == ST_GRANT) req_ready_d = arb_grant;
        if (next_state == ST_RESP)  rsp_valid_d = NUM_REQ'(1) << grant_id;
        eng_reset_d = (next_state == ST_ENG_RST) || wd_abort_pre;
        eng_start_d = (next_state == ST_START);
        busy_d      = (next_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_ready        <= '0;
            rsp_valid        <= '0;
            eng_reset        <= 1'b1;
            eng_start        <= 1'b0;
            busy             <= 1'b0;
            grant_id         <= '0;
            last_grant       <= IDX_W'(NUM_REQ - 1);
            eng_base_addr    <= '0;
            eng_number_bytes <= '0;
            rsp_hash         <= '0;
            rsp_error        <= 1'b0;
            watchdog         <= '0;
            rst_cnt          <= '0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            eng_reset <= eng_reset_d;
            eng_start <= eng_start_d;
            busy      <= busy_d;

            if (state == ST_IDLE && arb_any) begin
                grant_id         <= arb_idx;
                eng_base_addr    <= sel_addr;
                eng_number_bytes <= sel_len;
            end

            if (state == ST_ENG_RST) rst_cnt <= rst_cnt + RCNT_W'(1);
            else                     rst_cnt <= '0;

            if (state == ST_START)
                watchdog <= '0;
            else if (state == ST_WAIT && watchdog != '1)
                watchdog <= watchdog + 32'd1;

            // Digest wins over a same-cycle timeout.
            if (state == ST_GRANT && len_zero) begin
                rsp_hash  <= '0;
                rsp_error <= 1'b1;
            end else if (state == ST_WAIT && eng_out_ready) begin
                rsp_hash  <= eng_hash;
                rsp_error <= 1'b0;
            end else if (state == ST_WAIT && wd_timeout) begin
                rsp_hash  <= '0;
                rsp_error <= 1'b1;
            end

            if (state == ST_RESP && rsp_ack[grant_id]) last_grant <= grant_id;
        end
    end

endmodule
